// File: rtl/audipus_fp_pkg.sv
// Shared front-panel definitions: quadrature rest state, status-byte layout,
// delta limits and a Gray-transition classifier.
package audipus_fp_pkg;

   localparam logic [1:0] REST_STATE = 2'b11;
   localparam int SW_EVENT_BIT = 7;
   localparam int SW_LEVEL_BIT = 6;
   localparam int DELTA_MSB    = 5;
   localparam logic signed [5:0] DELTA_MAX = 6'sd31;
   localparam logic signed [5:0] DELTA_MIN = -6'sd32;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_CW,
      STEP_CCW,
      STEP_INVALID
   } step_e;

   // Position of an AB state along the clockwise cycle 11 -> 01 -> 00 -> 10.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      case (ab)
         2'b11:   return 2'd0;
         2'b01:   return 2'd1;
         2'b00:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   function automatic step_e classify(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
      logic [1:0] diff;
      diff = gray_pos(cur_ab) - gray_pos(prev_ab);
      case (diff)
         2'd0:    return STEP_NONE;
         2'd1:    return STEP_CW;
         2'd3:    return STEP_CCW;
         default: return STEP_INVALID;
      endcase
   endfunction

endpackage

// File: rtl/rotary_encoder_decoder_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output follows the
// synchronised input only after DEBOUNCE_CYCLES consecutive differing cycles.
module input_debounce #(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d = {sync_q[0], din};
      deb_d  = deb_q;
      cnt_d  = '0;
      // Any agreement restarts the count, so only an unbroken run flips the output.
      if (sync_q[1] != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 2'b11;
         deb_q  <= 1'b1;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout = deb_q;

endmodule

// File: rtl/rotary_encoder_decoder.sv
// Rotary encoder front end: debounced quadrature decoded into a saturating
// detent count plus push-switch level/event, cleared by an SPI read strobe.
module rotary_encoder_decoder
   import audipus_fp_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 100000,
   parameter int STEPS_PER_DETENT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       encoder_A,
   input  logic       encoder_B,
   input  logic       encoder_sw,
   input  logic       rotary_encoder_rd_stb,
   output logic [7:0] rotary_encoder_reg,
   output logic       encoder_event
);

   localparam logic signed [3:0] DETENT_STEPS = 4'(STEPS_PER_DETENT);

   logic a_deb, b_deb, sw_deb;
   logic [1:0] ab_cur;
   logic [1:0] ab_q, ab_d;
   logic signed [2:0] sub_q, sub_d;
   logic signed [3:0] sub_sum;
   logic signed [5:0] delta_q, delta_d, delta_base;
   logic signed [1:0] detent_inc;
   logic sw_event_q, sw_event_d;
   logic sw_level_q, sw_level_d;
   logic at_rest;
   step_e step;

   input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk(clk), .reset(reset), .din(encoder_A), .dout(a_deb));
   input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk(clk), .reset(reset), .din(encoder_B), .dout(b_deb));
   input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw (
      .clk(clk), .reset(reset), .din(encoder_sw), .dout(sw_deb));

   function automatic logic signed [5:0] sat_add(input logic signed [5:0] base,
                                                 input logic signed [1:0] inc);
      logic signed [6:0] sum;
      sum = {base[5], base} + {{5{inc[1]}}, inc};
      if (sum > 7'sd31)  return DELTA_MAX;
      if (sum < -7'sd32) return DELTA_MIN;
      return sum[5:0];
   endfunction

   assign ab_cur = {a_deb, b_deb};

   always_comb begin
      ab_d       = ab_cur;
      step       = classify(ab_q, ab_cur);
      sub_sum    = {sub_q[2], sub_q};
      detent_inc = 2'sd0;
      case (step)
         STEP_CW:  sub_sum = sub_sum + 4'sd1;
         STEP_CCW: sub_sum = sub_sum - 4'sd1;
         default:  sub_sum = {sub_q[2], sub_q};
      endcase
      sub_d   = sub_sum[2:0];
      at_rest = (ab_cur == REST_STATE) ||
                ((STEPS_PER_DETENT == 2) && (ab_cur == ~REST_STATE));
      // sub_sum is one bit wider so a full detent (+4) is visible before truncation.
      if (at_rest && (ab_cur != ab_q)) begin
         if (sub_sum == DETENT_STEPS) begin
            detent_inc = 2'sd1;
         end else if (sub_sum == -DETENT_STEPS) begin
            detent_inc = -2'sd1;
         end
         sub_d = 3'sd0;
      end

      delta_base = rotary_encoder_rd_stb ? 6'sd0 : delta_q;
      delta_d    = sat_add(delta_base, detent_inc);
      sw_level_d = ~sw_deb;
      sw_event_d = (sw_event_q & ~rotary_encoder_rd_stb) | (sw_level_d & ~sw_level_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ab_q       <= REST_STATE;
         sub_q      <= 3'sd0;
         delta_q    <= 6'sd0;
         sw_event_q <= 1'b0;
         sw_level_q <= 1'b0;
      end else begin
         ab_q       <= ab_d;
         sub_q      <= sub_d;
         delta_q    <= delta_d;
         sw_event_q <= sw_event_d;
         sw_level_q <= sw_level_d;
      end
   end

   assign rotary_encoder_reg[SW_EVENT_BIT]   = sw_event_q;
   assign rotary_encoder_reg[SW_LEVEL_BIT]   = sw_level_q;
   assign rotary_encoder_reg[DELTA_MSB:0]    = delta_q;
   assign encoder_event = (delta_q != 6'sd0) || sw_event_q;

endmodule

// File: tb/tb_rotary_encoder_decoder.sv
// Bench for rotary_encoder_decoder: directed scenarios plus random turning,
// compared every cycle against a behavioural model of the status byte.
module tb_rotary_encoder_decoder;

   localparam int D = 4;
   localparam int S = 4;

   logic clk = 1'b0;
   logic reset, enc_a, enc_b, enc_sw, rd_stb;
   logic [7:0] reg_o;
   logic ev_o;

   int errors = 0;
   int checks = 0;

   rotary_encoder_decoder #(.DEBOUNCE_CYCLES(D), .STEPS_PER_DETENT(S)) dut (
      .clk(clk),
      .reset(reset),
      .encoder_A(enc_a),
      .encoder_B(enc_b),
      .encoder_sw(enc_sw),
      .rotary_encoder_rd_stb(rd_stb),
      .rotary_encoder_reg(reg_o),
      .encoder_event(ev_o)
   );

   always #5 clk = ~clk;

   // Model state: raw sample history per input, debounced values, counts.
   bit   hist_a[$], hist_b[$], hist_sw[$];
   bit   m_deb_a, m_deb_b, m_deb_sw;
   bit [1:0] m_prev;
   int   m_sub, m_delta;
   bit   m_evt, m_lvl;
   bit   m_valid = 1'b0;
   bit [1:0] cw_seq [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

   // Flip when the last D synchronised samples all disagree with the output.
   function automatic bit flip_due(input bit q[$], input bit deb);
      for (int j = 2; j <= D + 1; j++)
         if (q[q.size() - 1 - j] == deb) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int cw_dir(input bit [1:0] from, input bit [1:0] to);
      for (int i = 0; i < 4; i++) begin
         if (cw_seq[i] == from && cw_seq[(i + 1) % 4] == to) return 1;
         if (cw_seq[i] == from && cw_seq[(i + 3) % 4] == to) return -1;
      end
      return 0;
   endfunction

   function automatic logic [7:0] m_reg();
      return {m_evt, m_lvl, 6'(m_delta)};
   endfunction

   task automatic model_edge(input bit r_a, input bit r_b, input bit r_sw,
                             input bit rst, input bit rd);
      bit [1:0] cur;
      int inc, d;
      bit new_lvl;
      if (rst) begin
         hist_a = {}; hist_b = {}; hist_sw = {};
         for (int i = 0; i < D + 2; i++) begin
            hist_a.push_back(1'b1); hist_b.push_back(1'b1); hist_sw.push_back(1'b1);
         end
         m_deb_a = 1'b1; m_deb_b = 1'b1; m_deb_sw = 1'b1;
         m_prev = 2'b11; m_sub = 0; m_delta = 0; m_evt = 1'b0; m_lvl = 1'b0;
         m_valid = 1'b1;
         return;
      end
      if (!m_valid) return;
      hist_a.push_back(r_a); hist_b.push_back(r_b); hist_sw.push_back(r_sw);
      while (hist_a.size() > D + 2) begin
         void'(hist_a.pop_front()); void'(hist_b.pop_front()); void'(hist_sw.pop_front());
      end
      cur = {m_deb_a, m_deb_b};
      inc = 0;
      if (cur != m_prev) begin
         m_sub += cw_dir(m_prev, cur);
         if (cur == 2'b11 || (S == 2 && cur == 2'b00)) begin
            if (m_sub == S) inc = 1;
            else if (m_sub == -S) inc = -1;
            m_sub = 0;
         end
      end
      m_prev = cur;
      d = (rd ? 0 : m_delta) + inc;
      if (d > 31) d = 31;
      if (d < -32) d = -32;
      m_delta = d;
      new_lvl = !m_deb_sw;
      m_evt = (rd ? 1'b0 : m_evt) | (new_lvl & !m_lvl);
      m_lvl = new_lvl;
      if (flip_due(hist_a, m_deb_a)) m_deb_a = !m_deb_a;
      if (flip_due(hist_b, m_deb_b)) m_deb_b = !m_deb_b;
      if (flip_due(hist_sw, m_deb_sw)) m_deb_sw = !m_deb_sw;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_edge(enc_a, enc_b, enc_sw, reset, rd_stb);
      end
   end

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (m_valid && !reset) begin
            check8("cycle_reg", reg_o, m_reg());
            check8("cycle_event", {7'd0, ev_o}, {7'd0, (m_delta != 0) || m_evt});
         end
      end
   end

   // Literal expectation pinned against both the DUT and the model.
   task automatic lit(input string name, input logic [7:0] exp_reg, input logic exp_ev);
      @(negedge clk);
      check8(name, reg_o, exp_reg);
      check8({name, "_model"}, m_reg(), exp_reg);
      check8({name, "_event"}, {7'd0, ev_o}, {7'd0, exp_ev});
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ab(input bit [1:0] ab);
      enc_a = ab[1];
      enc_b = ab[0];
      tick(10);
   endtask

   task automatic detent_cw();
      set_ab(2'b01); set_ab(2'b00); set_ab(2'b10); set_ab(2'b11);
   endtask

   task automatic detent_ccw();
      set_ab(2'b10); set_ab(2'b00); set_ab(2'b01); set_ab(2'b11);
   endtask

   task automatic pulse_rd();
      rd_stb = 1'b1;
      tick(1);
      rd_stb = 1'b0;
   endtask

   initial begin
      int p;
      int act;
      reset = 1'b1; enc_a = 1'b1; enc_b = 1'b1; enc_sw = 1'b1; rd_stb = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(2);
      lit("reset_state", 8'h00, 1'b0);

      // Single CW detent with exact update latency.
      set_ab(2'b01); set_ab(2'b00); set_ab(2'b10);
      enc_a = 1'b1; enc_b = 1'b1;
      tick(6);
      lit("cw_before_latency", 8'h00, 1'b0);
      tick(1);
      lit("cw_latency", 8'h01, 1'b1);
      tick(3);

      pulse_rd();
      lit("clear_after_cw", 8'h00, 1'b0);
      repeat (3) detent_ccw();
      lit("three_ccw", 8'h3D, 1'b1);
      pulse_rd();
      lit("read_clear", 8'h00, 1'b0);

      enc_a = 1'b0; tick(2); enc_a = 1'b1; tick(12);
      lit("glitch_a", 8'h00, 1'b0);
      set_ab(2'b01); set_ab(2'b11);
      lit("partial_turn", 8'h00, 1'b0);
      set_ab(2'b00); set_ab(2'b11);
      lit("invalid_jump", 8'h00, 1'b0);

      repeat (40) detent_cw();
      lit("sat_pos", 8'h1F, 1'b1);
      pulse_rd();
      repeat (40) detent_ccw();
      lit("sat_neg", 8'h20, 1'b1);
      pulse_rd();
      lit("clear_after_sat", 8'h00, 1'b0);

      enc_sw = 1'b0; tick(20);
      lit("sw_pressed", 8'hC0, 1'b1);
      enc_sw = 1'b1; tick(10);
      lit("sw_released", 8'h80, 1'b1);
      pulse_rd();
      lit("sw_cleared", 8'h00, 1'b0);
      enc_sw = 1'b0; tick(1); enc_sw = 1'b1; tick(10);
      lit("sw_glitch", 8'h00, 1'b0);

      // Read strobe coincident with a completing detent.
      detent_cw();
      set_ab(2'b01); set_ab(2'b00); set_ab(2'b10);
      enc_a = 1'b1; enc_b = 1'b1;
      tick(6);
      rd_stb = 1'b1; tick(1); rd_stb = 1'b0;
      lit("rd_with_detent", 8'h01, 1'b1);
      tick(3);

      // Reset mid-turn discards both partial and accumulated count.
      set_ab(2'b01); set_ab(2'b00);
      reset = 1'b1; tick(2); reset = 1'b0;
      lit("reset_mid_turn", 8'h00, 1'b0);
      tick(10);
      set_ab(2'b11);
      lit("after_reset_rest", 8'h00, 1'b0);

      // Random turning, glitches, presses and reads.
      p = 0;
      for (int n = 0; n < 300; n++) begin
         act = $urandom_range(0, 9);
         if (act < 6) begin
            p = (act < 3) ? (p + 1) % 4 : (p + 3) % 4;
            enc_a = cw_seq[p][1]; enc_b = cw_seq[p][0];
            tick($urandom_range(8, 14));
         end else if (act == 6) begin
            case ($urandom_range(0, 2))
               0: enc_a = !enc_a;
               1: enc_b = !enc_b;
               default: enc_sw = !enc_sw;
            endcase
            tick($urandom_range(1, D - 1));
            enc_a = cw_seq[p][1]; enc_b = cw_seq[p][0];
            enc_sw = (act == 6) ? enc_sw : 1'b1;
            tick(0);
            enc_sw = enc_sw;
            tick(8);
         end else if (act == 7) begin
            enc_sw = !enc_sw;
            tick($urandom_range(8, 14));
         end else begin
            pulse_rd();
            tick($urandom_range(0, 5));
         end
      end
      tick(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
